core_writeback_scoreboard: RTL and testbench
============================================

# core_writeback_scoreboard

Tracks every in-flight register write from dispatch until it retires through the register file's two write ports. Produces the per-EU pending-write masks and the `ldst_wait` / `wb_stall_branch` back-pressure that the dispatch hazard logic consumes. Sits between dispatch (slot A/B issue) and the register-file write side, arbitrating EU results onto write ports 0/1. Register index space is 16 (hword masks).

## Interface
Parameters:
- `LDST_DEPTH`, 2: outstanding loads tracked (in-order FIFO).
- `MUL_DEPTH`, 2: outstanding multiplies tracked (in-order FIFO).

Ports:
- Clock and reset: one clock; reset is asynchronous and active-high.
  - `clk`  in  1  core clock.
  - `rst`  in  1  asynchronous, active-high reset.
- Slot A dispatch:
  - `dispatch_a`  in  1  slot A issues this cycle.
  - `disp_a_eu`  in  2  target EU: 0=ALU, 1=MUL, 2=LDST, 3=BRANCH.
  - `disp_a_wb`  in  1  instruction writes `disp_a_rd` (load / link / ALU/MUL result).
  - `disp_a_rd`  in  4  destination register.
- Slot B dispatch: `dispatch_b`, `disp_b_eu`, `disp_b_wb`, `disp_b_rd`, same meaning for slot B. Slot B ALU ops go to ALU B.
- EU result requests:
  - `req_alu_a`, `req_alu_b`, `req_mul`, `req_ldst`, `req_branch`  in  1 each  EU result ready for its oldest tracked write.
- Grants and write ports:
  - `gnt`  out  5  one grant bit per requester, in order {branch, mul, ldst, alu_b, alu_a}; a requester holds its result until granted.
  - `wr_en`  out  2  write-port enables.
  - `wr_rd_0`, `wr_rd_1`  out  4  write-port destination registers.
  - `wr_sel_0`, `wr_sel_1`  out  3  data mux select: 0=alu_a, 1=alu_b, 2=ldst, 3=mul, 4=branch.
- Pending-write masks:
  - `mask_alu_a`, `mask_alu_b`, `mask_mul`, `mask_ldst`, `mask_branch`  out  16  one-hot OR of pending destinations per EU.
- Back-pressure:
  - `ldst_wait`  out  1  LDST FIFO full.
  - `mul_wait`  out  1  MUL FIFO full.
  - `wb_stall_branch`  out  1  branch slot occupied.

## Operation
- Storage per EU:
  - ALU A and ALU B each have a single slot (valid + rd).
  - Branch has a single slot.
  - MUL and LDST have in-order FIFOs of `rd`.
- Allocation happens only on `dispatch_x && disp_x_wb`. Stores, non-link branches and flag-only ops allocate nothing.
- A request is honoured only if its EU has a valid slot or head entry. A request against an empty EU is ignored (no grant, no port use).
- Arbitration is fixed priority: alu_a > alu_b > ldst > mul > branch.
  - The first winner takes port 0, the second takes port 1.
  - At most 2 grants per cycle.
  - Losers keep requesting. Starvation of low-priority EUs under continuous ALU traffic is accepted.
- `wr_rd_n` comes from the granted EU's slot or FIFO head. Unused ports drive `wr_en`=0, `wr_rd`=0, `wr_sel`=0.
- A grant frees the slot or pops the FIFO at the next edge.
- Masks are the one-hot decode of valid slots / FIFO entries, ORed per EU.
- Illegal inputs, to be flagged with bench assertions:
  - Both slots dispatching to MUL, LDST or BRANCH in the same cycle.
  - Dispatch into a full FIFO or an occupied branch slot.
- WAW ordering across different EUs is the dispatcher's responsibility.

## Timing
- Grants, `wr_*` and `gnt` are combinational from requests plus current state (same cycle).
- Dispatch allocation is registered. The mask bit is visible the cycle after `dispatch_x`.
- Grant release is registered. The mask bit clears the cycle after `gnt`. There is no bypass of the clear into the same-cycle mask.
- ALU/branch slot granted and re-dispatched in the same cycle: the slot loads the new rd and stays valid. The mask shows only the new rd next cycle.
- FIFO push and pop in the same cycle: count unchanged, head advances, new entry appended.
- `ldst_wait` = LDST count == `LDST_DEPTH`. `mul_wait` = MUL count == `MUL_DEPTH`. Both are registered state-derived.
- Pop from a full FIFO deasserts the wait flag the next cycle; the same-cycle pop does not unblock the same-cycle push.
- `wb_stall_branch` = branch slot valid. It drops the cycle after the branch grant.
- Reset (asynchronous, any cycle, including with requests pending):
  - All slots invalid, FIFO pointers and counts 0.
  - All masks 0; `ldst_wait`, `mul_wait`, `wb_stall_branch` 0.
  - `gnt`/`wr_en` forced 0 while `rst`=1.
  - In-flight results are dropped.

## Test plan
- **ALU path:** slot A ALU dispatch with rd=3, then `req_alu_a` two cycles later.
  - `mask_alu_a`=0x0008 from cycle+1 until the cycle after grant.
  - Grant cycle: `gnt`=00001, `wr_en`=01, `wr_rd_0`=3, `wr_sel_0`=0.
- **Three-way conflict:** `req_alu_a`, `req_ldst`, `req_mul` all valid in one cycle.
  - Port 0 = alu_a, port 1 = ldst.
  - mul not granted and `mask_mul` retained; mul is granted the following cycle if it requests alone.
- **LDST fill and drain:** dispatch loads rd=1 and rd=2 on consecutive cycles.
  - `ldst_wait`=1 and `mask_ldst`=0x0006.
  - Grant ldst: first `wr_rd`=1, then 2 (in-order). `ldst_wait`=0 the cycle after the first grant.
- **Branch link:** dispatch with wb=1, rd=14.
  - `wb_stall_branch`=1 and `mask_branch`=0x4000 until the cycle after `req_branch` is granted.
  - Repeat with wb=0: no stall, no mask.
- **Same-cycle ALU re-dispatch:** grant alu_b (rd=5) while slot B dispatches ALU with rd=7.
  - Next cycle `mask_alu_b`=0x0080.
- **Mid-operation reset:** assert `rst` with both FIFOs full.
  - All masks and wait flags are 0 immediately.
  - `wr_en`=0 even with every `req_*` high.

Source files
------------

// File: rtl/core_writeback_scoreboard.sv
// Writeback scoreboard: tracks in-flight register writes per execution unit,
// arbitrates ready results onto the two register-file write ports and
// produces pending-write masks plus dispatch back-pressure.

// In-order FIFO of destination registers with a per-entry valid bit so the
// pending mask can be built without pointer arithmetic.
module core_writeback_scoreboard_fifo #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  logic [3:0]  push_rd,
    input  logic        pop,
    output logic [3:0]  head_rd,
    output logic        nonempty,
    output logic        full,
    output logic [15:0] mask
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

    logic [DEPTH-1:0][3:0] mem_q, mem_d;
    logic [DEPTH-1:0]      vld_q, vld_d;
    logic [PW-1:0]         rp_q, rp_d, wp_q, wp_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  do_push, do_pop;

    // Push is refused while full, even if the head pops this same cycle.
    always_comb begin
        do_push = push && (cnt_q != FULL_CNT);
        do_pop  = pop && (cnt_q != '0);
        mem_d   = mem_q;
        vld_d   = vld_q;
        rp_d    = rp_q;
        wp_d    = wp_q;
        cnt_d   = cnt_q;
        if (do_pop) begin
            vld_d[rp_q] = 1'b0;
            rp_d        = (rp_q == LAST_PTR) ? '0 : rp_q + 1'b1;
        end
        if (do_push) begin
            mem_d[wp_q] = push_rd;
            vld_d[wp_q] = 1'b1;
            wp_d        = (wp_q == LAST_PTR) ? '0 : wp_q + 1'b1;
        end
        if (do_push && !do_pop)      cnt_d = cnt_q + 1'b1;
        else if (!do_push && do_pop) cnt_d = cnt_q - 1'b1;
    end

    // FIFO state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q <= '0;
            vld_q <= '0;
            rp_q  <= '0;
            wp_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            vld_q <= vld_d;
            rp_q  <= rp_d;
            wp_q  <= wp_d;
            cnt_q <= cnt_d;
        end
    end

    // One-hot OR of every live entry's destination.
    always_comb begin
        mask = '0;
        for (int j = 0; j < DEPTH; j++)
            if (vld_q[j]) mask[mem_q[j]] = 1'b1;
    end

    assign head_rd  = mem_q[rp_q];
    assign nonempty = (cnt_q != '0);
    assign full     = (cnt_q == FULL_CNT);
endmodule

module core_writeback_scoreboard #(
    parameter int LDST_DEPTH = 2,
    parameter int MUL_DEPTH  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dispatch_a,
    input  logic [1:0]  disp_a_eu,
    input  logic        disp_a_wb,
    input  logic [3:0]  disp_a_rd,
    input  logic        dispatch_b,
    input  logic [1:0]  disp_b_eu,
    input  logic        disp_b_wb,
    input  logic [3:0]  disp_b_rd,
    input  logic        req_alu_a,
    input  logic        req_alu_b,
    input  logic        req_mul,
    input  logic        req_ldst,
    input  logic        req_branch,
    output logic [4:0]  gnt,
    output logic [1:0]  wr_en,
    output logic [3:0]  wr_rd_0,
    output logic [3:0]  wr_rd_1,
    output logic [2:0]  wr_sel_0,
    output logic [2:0]  wr_sel_1,
    output logic [15:0] mask_alu_a,
    output logic [15:0] mask_alu_b,
    output logic [15:0] mask_mul,
    output logic [15:0] mask_ldst,
    output logic [15:0] mask_branch,
    output logic        ldst_wait,
    output logic        mul_wait,
    output logic        wb_stall_branch
);
    localparam logic [1:0] EU_ALU = 2'd0, EU_MUL = 2'd1, EU_LDST = 2'd2, EU_BR = 2'd3;

    logic       alu_a_vld_q, alu_a_vld_d, alu_b_vld_q, alu_b_vld_d, br_vld_q, br_vld_d;
    logic [3:0] alu_a_rd_q, alu_a_rd_d, alu_b_rd_q, alu_b_rd_d, br_rd_q, br_rd_d;
    logic       alloc_alu_a, alloc_alu_b, alloc_br_a, alloc_br_b;
    logic       push_ldst_a, push_ldst_b, push_mul_a, push_mul_b;
    logic       ldst_ne, mul_ne;
    logic [3:0] ldst_head, mul_head;
    logic [4:0] req_v;
    logic [4:0][3:0] src_rd;

    // Which storage each slot's dispatch allocates into (write-back only).
    always_comb begin
        alloc_alu_a = dispatch_a && disp_a_wb && (disp_a_eu == EU_ALU);
        alloc_alu_b = dispatch_b && disp_b_wb && (disp_b_eu == EU_ALU);
        alloc_br_a  = dispatch_a && disp_a_wb && (disp_a_eu == EU_BR);
        alloc_br_b  = dispatch_b && disp_b_wb && (disp_b_eu == EU_BR);
        push_ldst_a = dispatch_a && disp_a_wb && (disp_a_eu == EU_LDST);
        push_ldst_b = dispatch_b && disp_b_wb && (disp_b_eu == EU_LDST);
        push_mul_a  = dispatch_a && disp_a_wb && (disp_a_eu == EU_MUL);
        push_mul_b  = dispatch_b && disp_b_wb && (disp_b_eu == EU_MUL);
    end

    // Fixed-priority arbitration; bit index doubles as the data-mux select.
    always_comb begin
        req_v = {req_branch & br_vld_q, req_mul & mul_ne, req_ldst & ldst_ne,
                 req_alu_b & alu_b_vld_q, req_alu_a & alu_a_vld_q} & {5{~rst}};
        src_rd   = {br_rd_q, mul_head, ldst_head, alu_b_rd_q, alu_a_rd_q};
        gnt      = '0;
        wr_en    = '0;
        wr_rd_0  = '0;
        wr_rd_1  = '0;
        wr_sel_0 = '0;
        wr_sel_1 = '0;
        for (int i = 0; i < 5; i++) begin
            if (req_v[i]) begin
                if (!wr_en[0]) begin
                    wr_en[0] = 1'b1;
                    wr_rd_0  = src_rd[i];
                    wr_sel_0 = 3'(i);
                    gnt[i]   = 1'b1;
                end else if (!wr_en[1]) begin
                    wr_en[1] = 1'b1;
                    wr_rd_1  = src_rd[i];
                    wr_sel_1 = 3'(i);
                    gnt[i]   = 1'b1;
                end
            end
        end
    end

    // Single-entry slots: a new allocation wins over a same-cycle release.
    always_comb begin
        alu_a_vld_d = alloc_alu_a | (alu_a_vld_q & ~gnt[0]);
        alu_a_rd_d  = alloc_alu_a ? disp_a_rd : alu_a_rd_q;
        alu_b_vld_d = alloc_alu_b | (alu_b_vld_q & ~gnt[1]);
        alu_b_rd_d  = alloc_alu_b ? disp_b_rd : alu_b_rd_q;
        br_vld_d    = alloc_br_a | alloc_br_b | (br_vld_q & ~gnt[4]);
        br_rd_d     = alloc_br_a ? disp_a_rd : (alloc_br_b ? disp_b_rd : br_rd_q);
    end

    // Slot state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_a_vld_q <= 1'b0;
            alu_b_vld_q <= 1'b0;
            br_vld_q    <= 1'b0;
            alu_a_rd_q  <= '0;
            alu_b_rd_q  <= '0;
            br_rd_q     <= '0;
        end else begin
            alu_a_vld_q <= alu_a_vld_d;
            alu_b_vld_q <= alu_b_vld_d;
            br_vld_q    <= br_vld_d;
            alu_a_rd_q  <= alu_a_rd_d;
            alu_b_rd_q  <= alu_b_rd_d;
            br_rd_q     <= br_rd_d;
        end
    end

    // Slot masks.
    always_comb begin
        mask_alu_a  = '0;
        mask_alu_b  = '0;
        mask_branch = '0;
        if (alu_a_vld_q) mask_alu_a[alu_a_rd_q] = 1'b1;
        if (alu_b_vld_q) mask_alu_b[alu_b_rd_q] = 1'b1;
        if (br_vld_q)    mask_branch[br_rd_q]   = 1'b1;
    end

    core_writeback_scoreboard_fifo #(.DEPTH(LDST_DEPTH)) u_ldst (
        .clk(clk), .rst(rst),
        .push(push_ldst_a | push_ldst_b), .push_rd(push_ldst_a ? disp_a_rd : disp_b_rd),
        .pop(gnt[2]), .head_rd(ldst_head), .nonempty(ldst_ne), .full(ldst_wait),
        .mask(mask_ldst)
    );

    core_writeback_scoreboard_fifo #(.DEPTH(MUL_DEPTH)) u_mul (
        .clk(clk), .rst(rst),
        .push(push_mul_a | push_mul_b), .push_rd(push_mul_a ? disp_a_rd : disp_b_rd),
        .pop(gnt[3]), .head_rd(mul_head), .nonempty(mul_ne), .full(mul_wait),
        .mask(mask_mul)
    );

    assign wb_stall_branch = br_vld_q;
endmodule

// File: tb/tb_core_writeback_scoreboard.sv
// Self-checking bench for core_writeback_scoreboard: directed scenarios with
// constant expectations, then random traffic against a queue-based model.
module tb_core_writeback_scoreboard;
    localparam int LD = 2;
    localparam int MD = 2;

    logic clk = 1'b0, rst = 1'b1;
    logic dispatch_a, disp_a_wb, dispatch_b, disp_b_wb;
    logic [1:0] disp_a_eu, disp_b_eu;
    logic [3:0] disp_a_rd, disp_b_rd;
    logic req_alu_a, req_alu_b, req_mul, req_ldst, req_branch;
    logic [4:0] gnt;
    logic [1:0] wr_en;
    logic [3:0] wr_rd_0, wr_rd_1;
    logic [2:0] wr_sel_0, wr_sel_1;
    logic [15:0] mask_alu_a, mask_alu_b, mask_mul, mask_ldst, mask_branch;
    logic ldst_wait, mul_wait, wb_stall_branch;

    int n_tests = 0, n_fail = 0;

    // Reference model: plain slots and queues of destination registers.
    bit aa_v, ab_v, br_v;
    logic [3:0] aa_rd, ab_rd, br_rd;
    logic [3:0] ldq[$], mlq[$];

    core_writeback_scoreboard #(.LDST_DEPTH(LD), .MUL_DEPTH(MD)) dut (
        .clk(clk), .rst(rst),
        .dispatch_a(dispatch_a), .disp_a_eu(disp_a_eu), .disp_a_wb(disp_a_wb), .disp_a_rd(disp_a_rd),
        .dispatch_b(dispatch_b), .disp_b_eu(disp_b_eu), .disp_b_wb(disp_b_wb), .disp_b_rd(disp_b_rd),
        .req_alu_a(req_alu_a), .req_alu_b(req_alu_b), .req_mul(req_mul), .req_ldst(req_ldst),
        .req_branch(req_branch), .gnt(gnt), .wr_en(wr_en), .wr_rd_0(wr_rd_0), .wr_rd_1(wr_rd_1),
        .wr_sel_0(wr_sel_0), .wr_sel_1(wr_sel_1), .mask_alu_a(mask_alu_a), .mask_alu_b(mask_alu_b),
        .mask_mul(mask_mul), .mask_ldst(mask_ldst), .mask_branch(mask_branch),
        .ldst_wait(ldst_wait), .mul_wait(mul_wait), .wb_stall_branch(wb_stall_branch)
    );

    always #5 clk = ~clk;

    // Illegal dispatch patterns.
    always @(posedge clk) begin
        if (!rst) begin
            assert (!(dispatch_a && dispatch_b && disp_a_eu == disp_b_eu && disp_a_eu != 2'd0))
                else $error("illegal: both slots to same non-ALU EU");
            assert (!((dispatch_a && disp_a_wb && disp_a_eu == 2'd2 && ldst_wait) ||
                      (dispatch_b && disp_b_wb && disp_b_eu == 2'd2 && ldst_wait)))
                else $error("illegal: dispatch into full LDST FIFO");
            assert (!((dispatch_a && disp_a_wb && disp_a_eu == 2'd1 && mul_wait) ||
                      (dispatch_b && disp_b_wb && disp_b_eu == 2'd1 && mul_wait)))
                else $error("illegal: dispatch into full MUL FIFO");
            assert (!(((dispatch_a && disp_a_wb && disp_a_eu == 2'd3) ||
                       (dispatch_b && disp_b_wb && disp_b_eu == 2'd3)) && wb_stall_branch))
                else $error("illegal: dispatch into occupied branch slot");
        end
    end

    task automatic drive_idle();
        dispatch_a = 0; disp_a_eu = 0; disp_a_wb = 0; disp_a_rd = 0;
        dispatch_b = 0; disp_b_eu = 0; disp_b_wb = 0; disp_b_rd = 0;
        req_alu_a = 0; req_alu_b = 0; req_mul = 0; req_ldst = 0; req_branch = 0;
    endtask

    task automatic disp_a(input logic [1:0] eu, input logic wb, input logic [3:0] rd);
        dispatch_a = 1; disp_a_eu = eu; disp_a_wb = wb; disp_a_rd = rd;
    endtask

    task automatic disp_b(input logic [1:0] eu, input logic wb, input logic [3:0] rd);
        dispatch_b = 1; disp_b_eu = eu; disp_b_wb = wb; disp_b_rd = rd;
    endtask

    task automatic model_reset();
        aa_v = 0; ab_v = 0; br_v = 0; ldq.delete(); mlq.delete();
    endtask

    // Expected port usage: ready requesters listed in priority order, first two win.
    task automatic model_outputs(output logic [4:0] g, output logic [1:0] en,
                                 output logic [3:0] rd0, output logic [3:0] rd1,
                                 output logic [2:0] s0, output logic [2:0] s1);
        int sel_q[$];
        logic [3:0] rd_q[$];
        g = '0; en = '0; rd0 = '0; rd1 = '0; s0 = '0; s1 = '0;
        if (rst) return;
        if (req_alu_a && aa_v)               begin sel_q.push_back(0); rd_q.push_back(aa_rd); end
        if (req_alu_b && ab_v)               begin sel_q.push_back(1); rd_q.push_back(ab_rd); end
        if (req_ldst && ldq.size() > 0)      begin sel_q.push_back(2); rd_q.push_back(ldq[0]); end
        if (req_mul && mlq.size() > 0)       begin sel_q.push_back(3); rd_q.push_back(mlq[0]); end
        if (req_branch && br_v)              begin sel_q.push_back(4); rd_q.push_back(br_rd); end
        if (sel_q.size() > 0) begin g[sel_q[0]] = 1; en[0] = 1; rd0 = rd_q[0]; s0 = 3'(sel_q[0]); end
        if (sel_q.size() > 1) begin g[sel_q[1]] = 1; en[1] = 1; rd1 = rd_q[1]; s1 = 3'(sel_q[1]); end
    endtask

    // Retire granted writes, then allocate; fullness is judged before this cycle's pops.
    task automatic model_update();
        logic [4:0] g;
        logic [1:0] en;
        logic [3:0] r0, r1;
        logic [2:0] s0, s1;
        int ld_n, ml_n;
        model_outputs(g, en, r0, r1, s0, s1);
        ld_n = ldq.size();
        ml_n = mlq.size();
        if (g[0]) aa_v = 0;
        if (g[1]) ab_v = 0;
        if (g[2]) void'(ldq.pop_front());
        if (g[3]) void'(mlq.pop_front());
        if (g[4]) br_v = 0;
        if (dispatch_b && disp_b_wb)
            case (disp_b_eu)
                2'd0: begin ab_v = 1; ab_rd = disp_b_rd; end
                2'd1: if (ml_n < MD) mlq.push_back(disp_b_rd);
                2'd2: if (ld_n < LD) ldq.push_back(disp_b_rd);
                default: begin br_v = 1; br_rd = disp_b_rd; end
            endcase
        if (dispatch_a && disp_a_wb)
            case (disp_a_eu)
                2'd0: begin aa_v = 1; aa_rd = disp_a_rd; end
                2'd1: if (ml_n < MD) mlq.push_back(disp_a_rd);
                2'd2: if (ld_n < LD) ldq.push_back(disp_a_rd);
                default: begin br_v = 1; br_rd = disp_a_rd; end
            endcase
    endtask

    // Advance one clock; inputs are then driven 2 time units after the edge.
    task automatic tick();
        if (rst) model_reset(); else model_update();
        @(posedge clk); #2;
    endtask

    task automatic test_reset();
        drive_idle();
        req_alu_a = 1; req_alu_b = 1; req_mul = 1; req_ldst = 1; req_branch = 1;
        #1;
        n_tests++; if (gnt !== 5'b0 || wr_en !== 2'b0) begin n_fail++; $display("FAIL reset_gnt: gnt=%b wr_en=%b want 0/0", gnt, wr_en); end
        n_tests++; if ((mask_alu_a | mask_alu_b | mask_mul | mask_ldst | mask_branch) !== 16'h0) begin n_fail++; $display("FAIL reset_masks: got nonzero want 0"); end
        n_tests++; if ({ldst_wait, mul_wait, wb_stall_branch} !== 3'b0) begin n_fail++; $display("FAIL reset_waits: got %b want 000", {ldst_wait, mul_wait, wb_stall_branch}); end
        tick();
        rst = 0;
        #1;
        n_tests++; if (gnt !== 5'b0 || wr_en !== 2'b0) begin n_fail++; $display("FAIL empty_req: gnt=%b wr_en=%b want 0/0", gnt, wr_en); end
        drive_idle();
        tick();
    endtask

    task automatic test_alu_path();
        drive_idle(); disp_a(2'd0, 1, 4'd3); #1;
        n_tests++; if (mask_alu_a !== 16'h0) begin n_fail++; $display("FAIL alu_mask_c0: got %h want 0000", mask_alu_a); end
        tick(); drive_idle(); #1;
        n_tests++; if (mask_alu_a !== 16'h0008) begin n_fail++; $display("FAIL alu_mask_c1: got %h want 0008", mask_alu_a); end
        tick(); req_alu_a = 1; #1;
        n_tests++; if (gnt !== 5'b00001) begin n_fail++; $display("FAIL alu_gnt: got %b want 00001", gnt); end
        n_tests++; if (wr_en !== 2'b01 || wr_rd_0 !== 4'd3 || wr_sel_0 !== 3'd0) begin n_fail++; $display("FAIL alu_port: en=%b rd=%0d sel=%0d want 01/3/0", wr_en, wr_rd_0, wr_sel_0); end
        n_tests++; if (mask_alu_a !== 16'h0008) begin n_fail++; $display("FAIL alu_mask_grant: got %h want 0008", mask_alu_a); end
        tick(); drive_idle(); #1;
        n_tests++; if (mask_alu_a !== 16'h0) begin n_fail++; $display("FAIL alu_mask_clear: got %h want 0000", mask_alu_a); end
    endtask

    task automatic test_conflict();
        drive_idle(); disp_a(2'd0, 1, 4'd9); disp_b(2'd2, 1, 4'd4);
        tick(); drive_idle(); disp_a(2'd1, 1, 4'd11);
        tick(); drive_idle(); req_alu_a = 1; req_ldst = 1; req_mul = 1; #1;
        n_tests++; if (gnt !== 5'b00101 || wr_en !== 2'b11) begin n_fail++; $display("FAIL conf_gnt: gnt=%b en=%b want 00101/11", gnt, wr_en); end
        n_tests++; if (wr_rd_0 !== 4'd9 || wr_sel_0 !== 3'd0 || wr_rd_1 !== 4'd4 || wr_sel_1 !== 3'd2) begin n_fail++; $display("FAIL conf_ports: rd0=%0d s0=%0d rd1=%0d s1=%0d want 9/0/4/2", wr_rd_0, wr_sel_0, wr_rd_1, wr_sel_1); end
        tick(); drive_idle(); req_mul = 1; #1;
        n_tests++; if (mask_mul !== 16'h0800) begin n_fail++; $display("FAIL conf_mask_mul: got %h want 0800", mask_mul); end
        n_tests++; if (gnt !== 5'b01000 || wr_rd_0 !== 4'd11 || wr_sel_0 !== 3'd3) begin n_fail++; $display("FAIL conf_mul: gnt=%b rd=%0d sel=%0d want 01000/11/3", gnt, wr_rd_0, wr_sel_0); end
        tick(); drive_idle(); #1;
        n_tests++; if (mask_mul !== 16'h0) begin n_fail++; $display("FAIL conf_mul_clear: got %h want 0000", mask_mul); end
    endtask

    task automatic test_ldst_fill();
        drive_idle(); disp_a(2'd2, 1, 4'd1);
        tick(); drive_idle(); disp_a(2'd2, 1, 4'd2); #1;
        n_tests++; if (ldst_wait !== 1'b0) begin n_fail++; $display("FAIL ld_wait_half: got %b want 0", ldst_wait); end
        tick(); drive_idle(); req_ldst = 1; #1;
        n_tests++; if (ldst_wait !== 1'b1 || mask_ldst !== 16'h0006) begin n_fail++; $display("FAIL ld_full: wait=%b mask=%h want 1/0006", ldst_wait, mask_ldst); end
        n_tests++; if (wr_en !== 2'b01 || wr_rd_0 !== 4'd1 || wr_sel_0 !== 3'd2) begin n_fail++; $display("FAIL ld_first: en=%b rd=%0d sel=%0d want 01/1/2", wr_en, wr_rd_0, wr_sel_0); end
        tick(); #1;
        n_tests++; if (ldst_wait !== 1'b0 || mask_ldst !== 16'h0004) begin n_fail++; $display("FAIL ld_after_pop: wait=%b mask=%h want 0/0004", ldst_wait, mask_ldst); end
        n_tests++; if (wr_rd_0 !== 4'd2 || gnt !== 5'b00100) begin n_fail++; $display("FAIL ld_second: rd=%0d gnt=%b want 2/00100", wr_rd_0, gnt); end
        tick(); drive_idle(); #1;
        n_tests++; if (mask_ldst !== 16'h0) begin n_fail++; $display("FAIL ld_empty: got %h want 0000", mask_ldst); end
    endtask

    task automatic test_branch_link();
        drive_idle(); disp_b(2'd3, 1, 4'd14);
        tick(); drive_idle(); #1;
        n_tests++; if (wb_stall_branch !== 1'b1 || mask_branch !== 16'h4000) begin n_fail++; $display("FAIL br_set: stall=%b mask=%h want 1/4000", wb_stall_branch, mask_branch); end
        tick(); req_branch = 1; #1;
        n_tests++; if (gnt !== 5'b10000 || wr_rd_0 !== 4'd14 || wr_sel_0 !== 3'd4) begin n_fail++; $display("FAIL br_gnt: gnt=%b rd=%0d sel=%0d want 10000/14/4", gnt, wr_rd_0, wr_sel_0); end
        n_tests++; if (wb_stall_branch !== 1'b1) begin n_fail++; $display("FAIL br_stall_grant: got %b want 1", wb_stall_branch); end
        tick(); drive_idle(); #1;
        n_tests++; if (wb_stall_branch !== 1'b0 || mask_branch !== 16'h0) begin n_fail++; $display("FAIL br_clear: stall=%b mask=%h want 0/0000", wb_stall_branch, mask_branch); end
        disp_b(2'd3, 0, 4'd14);
        tick(); drive_idle(); req_branch = 1; #1;
        n_tests++; if (wb_stall_branch !== 1'b0 || mask_branch !== 16'h0 || gnt !== 5'b0) begin n_fail++; $display("FAIL br_nolink: stall=%b mask=%h gnt=%b want 0/0000/0", wb_stall_branch, mask_branch, gnt); end
        tick(); drive_idle();
    endtask

    task automatic test_redispatch();
        drive_idle(); disp_b(2'd0, 1, 4'd5);
        tick(); drive_idle(); req_alu_b = 1; disp_b(2'd0, 1, 4'd7); #1;
        n_tests++; if (gnt !== 5'b00010 || wr_rd_0 !== 4'd5 || wr_sel_0 !== 3'd1) begin n_fail++; $display("FAIL redisp_gnt: gnt=%b rd=%0d sel=%0d want 00010/5/1", gnt, wr_rd_0, wr_sel_0); end
        tick(); drive_idle(); req_alu_b = 1; #1;
        n_tests++; if (mask_alu_b !== 16'h0080) begin n_fail++; $display("FAIL redisp_mask: got %h want 0080", mask_alu_b); end
        n_tests++; if (wr_rd_0 !== 4'd7) begin n_fail++; $display("FAIL redisp_rd: got %0d want 7", wr_rd_0); end
        tick(); drive_idle();
    endtask

    task automatic test_random();
        logic [4:0] eg;
        logic [1:0] een;
        logic [3:0] er0, er1;
        logic [2:0] es0, es1;
        logic [15:0] m_aa, m_ab, m_ld, m_ml, m_br;
        for (int c = 0; c < 400; c++) begin
            dispatch_a = 1'($urandom); disp_a_eu = 2'($urandom); disp_a_wb = 1'($urandom); disp_a_rd = 4'($urandom);
            dispatch_b = 1'($urandom); disp_b_eu = 2'($urandom); disp_b_wb = 1'($urandom); disp_b_rd = 4'($urandom);
            if (dispatch_a && dispatch_b && disp_a_eu == disp_b_eu && disp_a_eu != 2'd0) dispatch_b = 0;
            if ((disp_a_eu == 2'd2 && ldq.size() == LD) || (disp_a_eu == 2'd1 && mlq.size() == MD) ||
                (disp_a_eu == 2'd3 && br_v)) disp_a_wb = 0;
            if ((disp_b_eu == 2'd2 && ldq.size() == LD) || (disp_b_eu == 2'd1 && mlq.size() == MD) ||
                (disp_b_eu == 2'd3 && br_v)) disp_b_wb = 0;
            req_alu_a = ($urandom_range(0, 3) != 0); req_alu_b = ($urandom_range(0, 3) != 0);
            req_ldst = ($urandom_range(0, 3) != 0); req_mul = ($urandom_range(0, 3) != 0);
            req_branch = ($urandom_range(0, 3) != 0);
            #1;
            model_outputs(eg, een, er0, er1, es0, es1);
            m_aa = '0; m_ab = '0; m_ld = '0; m_ml = '0; m_br = '0;
            if (aa_v) m_aa[aa_rd] = 1'b1;
            if (ab_v) m_ab[ab_rd] = 1'b1;
            if (br_v) m_br[br_rd] = 1'b1;
            foreach (ldq[k]) m_ld[ldq[k]] = 1'b1;
            foreach (mlq[k]) m_ml[mlq[k]] = 1'b1;
            n_tests++; if (gnt !== eg || wr_en !== een) begin n_fail++; $display("FAIL rnd_gnt c%0d: gnt=%b en=%b want %b/%b", c, gnt, wr_en, eg, een); end
            n_tests++; if (wr_rd_0 !== er0 || wr_rd_1 !== er1 || wr_sel_0 !== es0 || wr_sel_1 !== es1) begin n_fail++; $display("FAIL rnd_ports c%0d: %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d", c, wr_rd_0, wr_sel_0, wr_rd_1, wr_sel_1, er0, es0, er1, es1); end
            n_tests++; if ({mask_alu_a, mask_alu_b, mask_ldst, mask_mul, mask_branch} !== {m_aa, m_ab, m_ld, m_ml, m_br}) begin n_fail++; $display("FAIL rnd_masks c%0d: %h %h %h %h %h want %h %h %h %h %h", c, mask_alu_a, mask_alu_b, mask_ldst, mask_mul, mask_branch, m_aa, m_ab, m_ld, m_ml, m_br); end
            n_tests++; if ({ldst_wait, mul_wait, wb_stall_branch} !== {ldq.size() == LD, mlq.size() == MD, br_v}) begin n_fail++; $display("FAIL rnd_waits c%0d: got %b", c, {ldst_wait, mul_wait, wb_stall_branch}); end
            tick();
        end
        drive_idle();
    endtask

    task automatic test_mid_reset();
        drive_idle(); rst = 1;
        tick(); rst = 0;
        disp_a(2'd2, 1, 4'd1); disp_b(2'd1, 1, 4'd2);
        tick(); disp_a(2'd2, 1, 4'd3); disp_b(2'd1, 1, 4'd4);
        tick(); drive_idle(); #1;
        n_tests++; if (ldst_wait !== 1'b1 || mul_wait !== 1'b1 || mask_ldst !== 16'h000A || mask_mul !== 16'h0014) begin n_fail++; $display("FAIL mr_full: lw=%b mw=%b ml=%h mm=%h want 1/1/000a/0014", ldst_wait, mul_wait, mask_ldst, mask_mul); end
        req_alu_a = 1; req_alu_b = 1; req_mul = 1; req_ldst = 1; req_branch = 1;
        rst = 1; #1;
        n_tests++; if ((mask_alu_a | mask_alu_b | mask_mul | mask_ldst | mask_branch) !== 16'h0 || {ldst_wait, mul_wait, wb_stall_branch} !== 3'b0) begin n_fail++; $display("FAIL mr_clear: masks/waits nonzero after reset"); end
        n_tests++; if (wr_en !== 2'b0 || gnt !== 5'b0) begin n_fail++; $display("FAIL mr_wr_en: en=%b gnt=%b want 0/0", wr_en, gnt); end
        tick(); rst = 0; #1;
        n_tests++; if (wr_en !== 2'b0) begin n_fail++; $display("FAIL mr_dropped: en=%b want 00", wr_en); end
        drive_idle();
        tick();
    endtask

    initial begin
        drive_idle();
        model_reset();
        test_reset();
        test_alu_path();
        test_conflict();
        test_ldst_fill();
        test_branch_link();
        test_redispatch();
        test_random();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
